// File: rtl/bp_common_cfg_link_pkg.sv
// Shared types for the configuration-link command arbiter.
package bp_common_cfg_link_pkg;

  localparam int unsigned cfg_msg_type_width_gp = 4;
  localparam int unsigned cfg_addr_width_gp     = 40;
  localparam int unsigned cfg_data_width_gp     = 64;

  // Configuration-link memory message (command and response share the layout).
  typedef struct packed {
    logic [cfg_msg_type_width_gp-1:0] msg_type;
    logic [cfg_addr_width_gp-1:0]     addr;
    logic [cfg_data_width_gp-1:0]     data;
  } bp_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  localparam int unsigned cfg_arb_state_width_gp = 2;

  typedef enum logic [cfg_arb_state_width_gp-1:0] {
    e_idle    = 2'd0,
    e_send    = 2'd1,
    e_wait    = 2'd2,
    e_deliver = 2'd3
  } bp_cfg_arb_state_e;

endpackage

// File: rtl/bp_cfg_rr_arb.sv
// Round-robin selector: first valid requester at or after ptr_i, circular wrap.
module bp_cfg_rr_arb #(
  parameter int unsigned num_req_p = 2,
  localparam int unsigned lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]     v_i,
  input  logic [lg_num_req_lp-1:0] ptr_i,
  output logic [num_req_p-1:0]     grant_o,
  output logic [lg_num_req_lp-1:0] grant_id_o
);

  // Scan from the pointer with an explicit wrap so non-power-of-two counts work.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && v_i[lg_num_req_lp'(idx)]) begin
        found                              = 1'b1;
        grant_o[lg_num_req_lp'(idx)]       = 1'b1;
        grant_id_o                         = lg_num_req_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bp_cfg_cmd_arbiter.sv
// Single-outstanding round-robin arbiter in front of the configuration endpoint.
module bp_cfg_cmd_arbiter
  import bp_common_cfg_link_pkg::*;
#(
  parameter int unsigned num_req_p = 2,
  localparam int unsigned lg_num_req_lp = $clog2(num_req_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_req_p*cce_mem_msg_width_lp-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]                      req_cmd_v_i,
  output logic [num_req_p-1:0]                      req_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0]           req_resp_o,
  output logic [num_req_p-1:0]                      req_resp_v_o,
  input  logic [num_req_p-1:0]                      req_resp_yumi_i,
  output logic [cce_mem_msg_width_lp-1:0]           mem_cmd_o,
  output logic                                      mem_cmd_v_o,
  input  logic                                      mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]           mem_resp_i,
  input  logic                                      mem_resp_v_i,
  output logic                                      mem_resp_yumi_o,
  output logic                                      busy_o,
  output logic [lg_num_req_lp-1:0]                  owner_o
);

  bp_cfg_arb_state_e        state_r, state_n;
  logic [lg_num_req_lp-1:0] rr_ptr_r, rr_ptr_n, owner_r, grant_id;
  logic [num_req_p-1:0]     grant;
  bp_cce_mem_msg_s          cmd_r, resp_r, sel_cmd;
  logic                     cmd_load, resp_load;

  bp_cfg_rr_arb #(.num_req_p(num_req_p)) rr_arb (
    .v_i        (req_cmd_v_i),
    .ptr_i      (rr_ptr_r),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  // Mux the winning requester's command slot.
  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) sel_cmd = req_cmd_i[i*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
    end
  end

  // Pointer advances past the winner, wrapping by compare.
  always_comb begin
    rr_ptr_n = grant_id + lg_num_req_lp'(1);
    if (grant_id == lg_num_req_lp'(num_req_p - 1)) rr_ptr_n = '0;
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  // Captured command, response, owner and round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r <= '0;
      owner_r  <= '0;
      cmd_r    <= '0;
      resp_r   <= '0;
    end else begin
      if (cmd_load) begin
        cmd_r    <= sel_cmd;
        owner_r  <= grant_id;
        rr_ptr_r <= rr_ptr_n;
      end
      if (resp_load) resp_r <= mem_resp_i;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n         = state_r;
    req_cmd_ready_o = '0;
    req_resp_v_o    = '0;
    mem_cmd_v_o     = 1'b0;
    mem_resp_yumi_o = 1'b0;
    cmd_load        = 1'b0;
    resp_load       = 1'b0;
    case (state_r)
      e_idle: begin
        req_cmd_ready_o = grant;
        if (|(req_cmd_v_i & grant)) begin
          cmd_load = 1'b1;
          state_n  = e_send;
        end
      end
      e_send: begin
        mem_cmd_v_o = 1'b1;
        if (mem_cmd_ready_i) state_n = e_wait;
      end
      e_wait: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) begin
          resp_load = 1'b1;
          state_n   = e_deliver;
        end
      end
      e_deliver: begin
        req_resp_v_o[owner_r] = 1'b1;
        if (req_resp_yumi_i[owner_r]) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  assign mem_cmd_o  = cmd_r;
  assign req_resp_o = resp_r;
  assign busy_o     = (state_r != e_idle);
  assign owner_o    = owner_r;

endmodule

// File: tb/tb_bp_cfg_cmd_arbiter.sv
// Scoreboard bench for bp_cfg_cmd_arbiter with two requesters.
module tb_bp_cfg_cmd_arbiter;
  import bp_common_cfg_link_pkg::*;

  localparam int unsigned w_lp = cce_mem_msg_width_lp;

  typedef struct {
    int              owner;
    bp_cce_mem_msg_s cmd;
    bp_cce_mem_msg_s resp;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic [2*w_lp-1:0] req_cmd;
  logic [1:0]        req_cmd_v, req_cmd_ready, req_resp_v, req_resp_yumi;
  logic [w_lp-1:0]   req_resp, mem_cmd, mem_resp;
  logic              mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi, busy;
  logic [0:0]        owner;

  bp_cce_mem_msg_s cmd_a [2];
  exp_t            exp_q [$];
  int              model_ptr;
  int              n_checks, n_pass;

  bp_cfg_cmd_arbiter #(.num_req_p(2)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .req_cmd_i       (req_cmd),
    .req_cmd_v_i     (req_cmd_v),
    .req_cmd_ready_o (req_cmd_ready),
    .req_resp_o      (req_resp),
    .req_resp_v_o    (req_resp_v),
    .req_resp_yumi_i (req_resp_yumi),
    .mem_cmd_o       (mem_cmd),
    .mem_cmd_v_o     (mem_cmd_v),
    .mem_cmd_ready_i (mem_cmd_ready),
    .mem_resp_i      (mem_resp),
    .mem_resp_v_i    (mem_resp_v),
    .mem_resp_yumi_o (mem_resp_yumi),
    .busy_o          (busy),
    .owner_o         (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic bp_cce_mem_msg_s resp_of(input bp_cce_mem_msg_s c);
    bp_cce_mem_msg_s r;
    r          = c;
    r.msg_type = c.msg_type ^ 4'h8;
    r.data     = c.data ^ 64'hDEAD_BEEF_0000_FFFF;
    return r;
  endfunction

  task automatic do_reset();
    reset_n       = 1'b0;
    req_cmd_v     = '0;
    req_resp_yumi = '0;
    mem_cmd_ready = 1'b0;
    mem_resp_v    = 1'b0;
    mem_resp      = '0;
    model_ptr     = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // One full transaction; expectations come from the bench's round-robin model.
  task automatic run_txn(input logic [1:0] vmask, input int rdy_dly, input int resp_dly,
                         input int yumi_dly, input bit stray_yumi);
    int         win, busy_cnt;
    logic [1:0] oh;
    exp_t       e, ex;
    win = vmask[model_ptr] ? model_ptr : 1 - model_ptr;
    oh  = (win == 0) ? 2'b01 : 2'b10;
    e.owner = win;
    e.cmd   = cmd_a[win];
    e.resp  = resp_of(cmd_a[win]);
    exp_q.push_back(e);
    model_ptr = (win == 1) ? 0 : win + 1;
    busy_cnt  = 0;
    req_cmd   = {cmd_a[1], cmd_a[0]};
    req_cmd_v = vmask;
    @(negedge clk);
    check("grant", 128'(req_cmd_ready), 128'(oh));
    check("idle_busy", 128'(busy), 128'(1'b0));
    @(posedge clk); #1;
    req_cmd_v = vmask & ~oh;
    for (int c = 0; c <= rdy_dly; c++) begin
      mem_cmd_ready = (c == rdy_dly);
      @(negedge clk);
      busy_cnt += int'(busy);
      check("cmd_v", 128'(mem_cmd_v), 128'(1'b1));
      check("cmd_data", 128'(mem_cmd), 128'(exp_q[0].cmd));
      check("send_yumi", 128'(mem_resp_yumi), 128'(1'b0));
      check("send_ready", 128'(req_cmd_ready), 128'(2'b00));
      @(posedge clk); #1;
    end
    mem_cmd_ready = 1'b0;
    for (int c = 0; c <= resp_dly; c++) begin
      mem_resp_v = (c == resp_dly);
      if (c == resp_dly) mem_resp = e.resp;
      @(negedge clk);
      busy_cnt += int'(busy);
      check("wait_yumi", 128'(mem_resp_yumi), 128'(c == resp_dly));
      check("wait_resp_v", 128'(req_resp_v), 128'(2'b00));
      check("owner", 128'(owner), 128'(win));
      @(posedge clk); #1;
    end
    mem_resp_v = 1'b0;
    mem_resp   = ~e.resp;
    req_cmd_v  = ~oh;
    for (int c = 0; c <= yumi_dly; c++) begin
      req_resp_yumi = (c == yumi_dly) ? oh : (stray_yumi ? ~oh : 2'b00);
      @(negedge clk);
      busy_cnt += int'(busy);
      check("deliver_ready", 128'(req_cmd_ready), 128'(2'b00));
      if (c == yumi_dly && exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check("resp_v", 128'(req_resp_v), 128'((ex.owner == 0) ? 2'b01 : 2'b10));
        check("resp_data", 128'(req_resp), 128'(ex.resp));
      end else begin
        check("resp_v_hold", 128'(req_resp_v), 128'(oh));
        check("resp_data_hold", 128'(req_resp), 128'(e.resp));
      end
      @(posedge clk); #1;
    end
    req_resp_yumi = '0;
    req_cmd_v     = '0;
    @(negedge clk);
    check("idle_after", 128'(busy), 128'(1'b0));
    check("busy_cycles", 128'(busy_cnt), 128'(rdy_dly + resp_dly + yumi_dly + 3));
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    req_cmd  = '0;
    cmd_a[0] = '{msg_type: 4'h1, addr: 40'h00_0020_0004, data: 64'h0000_0000_1111_2222};
    cmd_a[1] = '{msg_type: 4'h2, addr: 40'h00_0030_0010, data: 64'h3333_4444_5555_6666};
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_cmd_v", 128'(mem_cmd_v), 128'(1'b0));
    check("rst_cmd", 128'(mem_cmd), 128'(0));
    check("rst_resp_v", 128'(req_resp_v), 128'(2'b00));
    check("rst_resp", 128'(req_resp), 128'(0));
    check("rst_owner", 128'(owner), 128'(1'b0));
    check("rst_ready", 128'(req_cmd_ready), 128'(2'b00));
    @(posedge clk); #1;

    // Single request from requester 0
    run_txn(2'b01, 0, 2, 0, 1'b0);

    // Fairness: both valid, owners alternate from a fresh pointer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cmd_a[0].data = 64'(k * 16 + 1);
      cmd_a[1].data = 64'(k * 16 + 2);
      run_txn(2'b11, 0, 0, 0, 1'b0);
    end

    // Backpressure on command and response, requester 1
    cmd_a[1].addr = 40'h00_0040_0008;
    run_txn(2'b10, 5, 1, 3, 1'b0);

    // Non-owner yumi while requester 1 owns the delivery
    run_txn(2'b10, 0, 0, 2, 1'b1);

    // Stray endpoint response while idle stays pending until the next wait
    mem_resp   = resp_of(cmd_a[0]);
    mem_resp_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stray_yumi", 128'(mem_resp_yumi), 128'(1'b0));
      check("stray_resp_v", 128'(req_resp_v), 128'(2'b00));
      @(posedge clk); #1;
    end
    run_txn(2'b01, 2, 0, 0, 1'b0);

    // Mid-transaction reset: pointer returns to 0
    req_cmd   = {cmd_a[1], cmd_a[0]};
    req_cmd_v = 2'b01;
    @(negedge clk);
    check("mr_grant", 128'(req_cmd_ready), 128'(2'b01));
    @(posedge clk); #1;
    req_cmd_v     = '0;
    mem_cmd_ready = 1'b1;
    @(posedge clk); #1;
    mem_cmd_ready = 1'b0;
    mem_resp_v    = 1'b0;
    @(negedge clk);
    check("mr_busy_wait", 128'(busy), 128'(1'b1));
    #2;
    mem_resp_v = 1'b1;
    reset_n    = 1'b0;
    #1;
    check("mr_busy", 128'(busy), 128'(1'b0));
    check("mr_cmd_v", 128'(mem_cmd_v), 128'(1'b0));
    check("mr_yumi", 128'(mem_resp_yumi), 128'(1'b0));
    check("mr_cmd", 128'(mem_cmd), 128'(0));
    check("mr_owner", 128'(owner), 128'(1'b0));
    mem_resp_v = 1'b0;
    model_ptr  = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_txn(2'b11, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
